// File: rtl/control_unit.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch/decode/execute/writeback.
// Latency: outputs follow the state register (PC_Write in BRANCH also follows Zero); LW=5, SW/R/ADDI=4, BEQ=3, unknown=2 cycles.
// Backpressure: none; the FSM advances every clock and never stalls.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset (forces FETCH)
//   Op, Funct, Zero   - opcode / function fields of the instruction register, ALU zero flag
//   PC_Write .. PC_Src - datapath enables and mux selects
//   State_o           - current state encoding for debug
//
// Build option: define CTRL_BEQ_EN to enable BEQ (BRANCH state, Zero-qualified PC_Write).
// Without it, opcode 000100 is treated like any other unknown opcode and Zero is ignored.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PC_Write,
    output logic       I_or_D,
    output logic       Mem_Write,
    output logic       IR_Write,
    output logic       Reg_Dst,
    output logic       Mem_to_Reg,
    output logic       Reg_Write,
    output logic       ALU_Src_A,
    output logic [1:0] ALU_Src_B,
    output logic [2:0] ALU_Control,
    output logic       PC_Src,
    output logic [3:0] State_o
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef CTRL_BEQ_EN
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state;
    logic [3:0] state_nxt;

`ifndef CTRL_BEQ_EN
    // Zero only matters for BEQ; keep it visibly consumed in this build.
    logic unused_zero;
    assign unused_zero = Zero;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Op is only consulted in DECODE and MEMADR; the IR is frozen outside FETCH.
    // Unused encodings 11-15 fall through to the FETCH default.
    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:   state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTE;
                    OP_ADDI:      state_nxt = ADDIEX;
`ifdef CTRL_BEQ_EN
                    OP_BEQ:       state_nxt = BRANCH;
`endif
                    default:      state_nxt = FETCH;
                endcase
            end
            MEMADR:  state_nxt = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_nxt = MEMWB;
            EXECUTE: state_nxt = ALUWB;
            ADDIEX:  state_nxt = ADDIWB;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        PC_Write    = 1'b0;
        I_or_D      = 1'b0;
        Mem_Write   = 1'b0;
        IR_Write    = 1'b0;
        Reg_Dst     = 1'b0;
        Mem_to_Reg  = 1'b0;
        Reg_Write   = 1'b0;
        ALU_Src_A   = 1'b0;
        ALU_Src_B   = 2'b00;
        ALU_Control = 3'b000;
        PC_Src      = 1'b0;
        case (state)
            FETCH: begin
                // PC + 4 computed and written back while the instruction is latched.
                IR_Write    = 1'b1;
                ALU_Src_B   = 2'b01;
                ALU_Control = ALU_ADD;
                PC_Write    = 1'b1;
            end
            DECODE: begin
                // Speculative branch target: PC + (SignImm << 2).
                ALU_Src_B   = 2'b11;
                ALU_Control = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                ALU_Src_A   = 1'b1;
                ALU_Src_B   = 2'b10;
                ALU_Control = ALU_ADD;
            end
            MEMRD: begin
                I_or_D = 1'b1;
            end
            MEMWR: begin
                I_or_D    = 1'b1;
                Mem_Write = 1'b1;
            end
            MEMWB: begin
                Mem_to_Reg = 1'b1;
                Reg_Write  = 1'b1;
            end
            EXECUTE: begin
                ALU_Src_A = 1'b1;
                case (Funct)
                    FN_ADD:  ALU_Control = ALU_ADD;
                    FN_SUB:  ALU_Control = ALU_SUB;
                    FN_AND:  ALU_Control = ALU_AND;
                    FN_OR:   ALU_Control = ALU_OR;
                    FN_SLT:  ALU_Control = ALU_SLT;
                    default: ALU_Control = ALU_ADD;
                endcase
            end
            ALUWB: begin
                Reg_Dst   = 1'b1;
                Reg_Write = 1'b1;
            end
            ADDIWB: begin
                Reg_Write = 1'b1;
            end
`ifdef CTRL_BEQ_EN
            BRANCH: begin
                // Compare A - B; take the target held in ALU_Out only when equal.
                ALU_Src_A   = 1'b1;
                ALU_Control = ALU_SUB;
                PC_Src      = 1'b1;
                PC_Write    = Zero;
            end
`endif
            default: ;
        endcase
    end

    assign State_o = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected state/output trace queued, then compared each cycle.
// Latency: one queue entry per clock, compared on the falling edge.
// Backpressure: not applicable.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PC_Write, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write;
    logic       ALU_Src_A, PC_Src;
    logic [1:0] ALU_Src_B;
    logic [2:0] ALU_Control;
    logic [3:0] State_o;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .Op          (Op),
        .Funct       (Funct),
        .Zero        (Zero),
        .PC_Write    (PC_Write),
        .I_or_D      (I_or_D),
        .Mem_Write   (Mem_Write),
        .IR_Write    (IR_Write),
        .Reg_Dst     (Reg_Dst),
        .Mem_to_Reg  (Mem_to_Reg),
        .Reg_Write   (Reg_Write),
        .ALU_Src_A   (ALU_Src_A),
        .ALU_Src_B   (ALU_Src_B),
        .ALU_Control (ALU_Control),
        .PC_Src      (PC_Src),
        .State_o     (State_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PC_Write, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
    //  ALU_Src_A, ALU_Src_B[1:0], ALU_Control[2:0], PC_Src}
    logic [13:0] obs_ctrl;
    assign obs_ctrl = {PC_Write, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
                       ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src};

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Expected control word for a state, written straight from the state/output table.
    function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn, input logic z);
        logic pcw, iord, mw, irw, rd, m2r, rw, sa, pcs;
        logic [1:0] sb_sel;
        logic [2:0] alu;
        {pcw, iord, mw, irw, rd, m2r, rw, sa, pcs} = '0;
        sb_sel = 2'b00;
        alu    = 3'b000;
        case (st)
            4'd0:  begin irw = 1; sb_sel = 2'b01; alu = 3'b010; pcw = 1; end
            4'd1:  begin sb_sel = 2'b11; alu = 3'b010; end
            4'd2, 4'd9: begin sa = 1; sb_sel = 2'b10; alu = 3'b010; end
            4'd3:  iord = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iord = 1; mw = 1; end
            4'd6: begin
                sa = 1;
                case (fn)
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
            end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; alu = 3'b110; pcs = 1; pcw = z; end
            4'd10: rw = 1;
            default: ;
        endcase
        return {pcw, iord, mw, irw, rd, m2r, rw, sa, sb_sel, alu, pcs};
    endfunction

    // Queue the expected trace for one instruction starting in FETCH, then compare it
    // cycle by cycle. stop_after > 0 abandons the instruction after that many cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int stop_after);
        logic [3:0] seq[$];
        exp_t e;
        int   n;
        case (op)
            6'b100011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'b101011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            6'b000000: seq = '{4'd0, 4'd1, 4'd6, 4'd7};
            6'b001000: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
`ifdef CTRL_BEQ_EN
            6'b000100: seq = '{4'd0, 4'd1, 4'd8};
`endif
            default:   seq = '{4'd0, 4'd1};
        endcase
        Op    = op;
        Funct = fn;
        Zero  = z;
        foreach (seq[i]) sb.push_back({seq[i], exp_ctrl(seq[i], fn, z)});
        #1;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", 16'(State_o), 16'(e.st));
            check("ctrl", 16'(obs_ctrl), 16'(e.ctrl));
            check("mw_rw_excl", 16'(Mem_Write & Reg_Write), 16'd0);
            n++;
            if (stop_after > 0 && n == stop_after) begin
                sb.delete();
                return;
            end
            @(negedge clk);
        end
        check("back_to_fetch", 16'(State_o), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        Op    = 6'd0;
        Funct = 6'd0;
        Zero  = 1'b0;
        #2;
        check("reset_state", 16'(State_o), 16'd0);
        check("reset_ctrl", 16'(obs_ctrl), 16'(exp_ctrl(4'd0, 6'd0, 1'b0)));
        @(negedge clk);
        @(negedge clk);
        check("reset_held", 16'(State_o), 16'd0);
        reset = 1'b0;

        run_instr(6'b100011, 6'd0, 1'b0, 0);          // LW
        run_instr(6'b101011, 6'd0, 1'b1, 0);          // SW, Zero irrelevant
        run_instr(6'b000000, 6'b101010, 1'b0, 0);     // slt
        run_instr(6'b000000, 6'b100000, 1'b0, 0);     // add
        run_instr(6'b000000, 6'b100010, 1'b1, 0);     // sub
        run_instr(6'b000000, 6'b100100, 1'b0, 0);     // and
        run_instr(6'b000000, 6'b100101, 1'b0, 0);     // or
        run_instr(6'b000000, 6'b000111, 1'b0, 0);     // unknown funct -> add
        run_instr(6'b001000, 6'b100010, 1'b0, 0);     // ADDI
        run_instr(6'b000100, 6'd0, 1'b1, 0);          // BEQ taken (NOP when BEQ disabled)
        run_instr(6'b000100, 6'd0, 1'b0, 0);          // BEQ not taken
        run_instr(6'b111111, 6'd0, 1'b1, 0);          // unknown opcode

        // Abandon a LW in MEMRD with an asynchronous reset between clock edges.
        run_instr(6'b100011, 6'd0, 1'b0, 4);
        check("in_memrd", 16'(State_o), 16'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", 16'(State_o), 16'd0);
        check("async_rst_irw", 16'(IR_Write), 16'd1);
        check("async_rst_ctrl", 16'(obs_ctrl), 16'(exp_ctrl(4'd0, 6'd0, 1'b0)));
        @(negedge clk);
        check("rst_over_edge", 16'(State_o), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_after_rst", 16'(State_o), 16'd1);
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        check("rst_pulse", 16'(State_o), 16'd0);

        run_instr(6'b100011, 6'd0, 1'b0, 0);          // recovers with a full LW
        run_instr(6'b001000, 6'd0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
